// File: rtl/seq_arbiter.sv
// ---------------------------------------------------------------------------
// seq_arbiter
//
// Shares one serial pattern-detector FSM between four requesters. A winner is
// picked round-robin, the detector is flushed for one cycle, then the winner's
// serial bits are streamed into the detector until the burst ends (last
// marker, 16-bit limit, or the owner dropping its request). Matches reported
// by the detector (fsm_state == S2) are turned into a one-cycle pulse tagged
// with the owner, and counted in a saturating 8-bit counter.
//
// Ports
//   clk         in   clock, all logic on rising edge
//   rst         in   synchronous active-high reset
//   req         in   [3:0] per-requester request level, held for whole burst
//   req_bit     in   [3:0] per-requester serial data bit
//   req_last    in   [3:0] per-requester last-bit marker (owner line only)
//   fsm_state   in   [1:0] detector state: 00 IDLE, 01 S1, 10 S2
//   grant       out  [3:0] one-hot grant, registered
//   fsm_in      out  serial bit to the detector
//   fsm_rst     out  reset pulse to the detector
//   busy        out  high whenever the controller is not idle
//   match_pulse out  one-cycle pulse per detected S2
//   match_id    out  [1:0] owner index tied to match_pulse
//   match_cnt   out  [7:0] saturating count of matches since reset
// ---------------------------------------------------------------------------
module seq_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] req_bit,
  input  logic [3:0] req_last,
  input  logic [1:0] fsm_state,
  output logic [3:0] grant,
  output logic       fsm_in,
  output logic       fsm_rst,
  output logic       busy,
  output logic       match_pulse,
  output logic [1:0] match_id,
  output logic [7:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    STREAM  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e     state_q;
  logic [1:0] owner_q;
  logic [1:0] lastWinner_q;
  logic [3:0] grant_q;
  logic [3:0] bitCnt_q;
  logic       matchPulse_q;
  logic [1:0] matchId_q;
  logic [7:0] matchCnt_q;

  logic [1:0] winner_d;
  logic [1:0] candidate;
  logic       found;
  logic       ownerReq;
  logic       ownerLast;
  logic       matchDet;

  // Round-robin pick: scan the four requesters starting one past the last
  // winner; the fourth candidate wraps back onto the last winner itself so a
  // lone requester can win again.
  always_comb begin
    winner_d  = lastWinner_q;
    candidate = lastWinner_q;
    found     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      candidate = lastWinner_q + 2'(i);
      if (!found && req[candidate]) begin
        winner_d = candidate;
        found    = 1'b1;
      end
    end
  end

  // Only the owner's lines matter once a burst has started; everyone else is
  // ignored until the controller is back in IDLE.
  assign ownerReq  = req[owner_q];
  assign ownerLast = req_last[owner_q];

  // The data bit passes straight through while streaming, but is forced low
  // in an abort cycle (owner has dropped its request) so no stray bit reaches
  // the detector.
  assign fsm_in = (state_q == STREAM) && ownerReq && req_bit[owner_q];

  // The detector is held in reset both while the arbiter itself is in reset
  // and during the one-cycle flush before each stream.
  assign fsm_rst = rst || (state_q == FLUSH);

  // Detector state is only trusted while it is fed by the owner's stream or
  // is settling in the cycle after it; IDLE and FLUSH values are stale.
  assign matchDet = ((state_q == STREAM) || (state_q == RELEASE)) &&
                    (fsm_state == 2'b10);

  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;
  assign match_pulse = matchPulse_q;
  assign match_id    = matchId_q;
  assign match_cnt   = matchCnt_q;

  // Main controller. Reset lands in IDLE with last winner 3 so requester 0
  // has first priority. A reset mid-burst simply abandons the burst: no
  // RELEASE cycle, and any pending match report is discarded. The match
  // pulse is registered one cycle after detection and the counter steps on
  // the same edge, stopping at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      lastWinner_q <= 2'd3;
      grant_q      <= 4'b0000;
      bitCnt_q     <= 4'd0;
      matchPulse_q <= 1'b0;
      matchId_q    <= 2'd0;
      matchCnt_q   <= 8'd0;
    end else begin
      matchPulse_q <= matchDet;
      if (matchDet) begin
        matchId_q <= owner_q;
        if (matchCnt_q != 8'hFF) begin
          matchCnt_q <= matchCnt_q + 8'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (req != 4'b0000) begin
            owner_q <= winner_d;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          grant_q  <= 4'b0001 << owner_q;
          bitCnt_q <= 4'd0;
          state_q  <= STREAM;
        end
        STREAM: begin
          if (!ownerReq) begin
            grant_q <= 4'b0000;
            state_q <= RELEASE;
          end else begin
            bitCnt_q <= bitCnt_q + 4'd1;
            if (ownerLast || (bitCnt_q == 4'd15)) begin
              grant_q <= 4'b0000;
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: begin
          lastWinner_q <= owner_q;
          state_q      <= IDLE;
        end
        default: begin
          grant_q <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_arbiter
//
// Directed bench for seq_arbiter. A small model of the shared detector
// (IDLE -1-> S1 -1-> S2, any other input or leaving S2 returns to IDLE) is
// driven by fsm_in/fsm_rst; an override lets individual steps force
// fsm_state to a chosen value. Each step drives inputs just after a falling
// edge and checks outputs 1 ns later, i.e. the register values set by the
// previous rising edge plus combinational paths from the new inputs.
// ---------------------------------------------------------------------------
module tb_seq_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] req_bit = 4'b0000;
  logic [3:0] req_last = 4'b0000;
  logic [1:0] fsm_state;
  logic [3:0] grant;
  logic       fsm_in;
  logic       fsm_rst;
  logic       busy;
  logic       match_pulse;
  logic [1:0] match_id;
  logic [7:0] match_cnt;

  logic [1:0] detState = 2'b00;
  logic       ovrEn = 1'b0;
  logic [1:0] ovrVal = 2'b00;

  int compared = 0;
  int mismatched = 0;

  seq_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_bit     (req_bit),
    .req_last    (req_last),
    .fsm_state   (fsm_state),
    .grant       (grant),
    .fsm_in      (fsm_in),
    .fsm_rst     (fsm_rst),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_id    (match_id),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  assign fsm_state = ovrEn ? ovrVal : detState;

  // Stand-in for the shared detector: spots two consecutive ones.
  always @(posedge clk) begin
    if (fsm_rst) begin
      detState <= 2'b00;
    end else begin
      case (detState)
        2'b00:   detState <= fsm_in ? 2'b01 : 2'b00;
        2'b01:   detState <= fsm_in ? 2'b10 : 2'b00;
        default: detState <= 2'b00;
      endcase
    end
  end

  // One cycle of stimulus, applied after the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] b,
                               input logic [3:0] l, input logic oe = 1'b0,
                               input logic [1:0] ov = 2'b00,
                               input logic rs = 1'b0);
    @(negedge clk);
    req      = r;
    req_bit  = b;
    req_last = l;
    ovrEn    = oe;
    ovrVal   = ov;
    rst      = rs;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] expVal);
    compared++;
    assert (obs === expVal) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expVal);
    end
  endtask

  task automatic checkCore(input string tag, input logic [3:0] g,
                           input logic fi, input logic fr, input logic bz);
    checkOutput({tag, "/grant"}, 8'(grant), 8'(g));
    checkOutput({tag, "/fsm_in"}, 8'(fsm_in), 8'(fi));
    checkOutput({tag, "/fsm_rst"}, 8'(fsm_rst), 8'(fr));
    checkOutput({tag, "/busy"}, 8'(busy), 8'(bz));
  endtask

  task automatic checkMatch(input string tag, input logic p,
                            input logic [1:0] id, input logic [7:0] cnt);
    checkOutput({tag, "/match_pulse"}, 8'(match_pulse), 8'(p));
    checkOutput({tag, "/match_id"}, 8'(match_id), 8'(id));
    checkOutput({tag, "/match_cnt"}, match_cnt, cnt);
  endtask

  // Short burst for requester 2 whose single stream cycle is forced to S2.
  task automatic runBurst();
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'b10);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
  endtask

  // Safety net in case the run wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] eg;

    // Reset cycle and first cycle out of reset.
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
    checkCore("reset", 4'b0000, 1'b0, 1'b1, 1'b0);
    checkMatch("reset", 1'b0, 2'd0, 8'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkCore("postreset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // All four requesting: rotation 0,1,2,3,0; non-owner last ignored.
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % 4));
      applyStimulus(4'b1111, 4'b0000, 4'b0000);
      checkCore("rr idle", 4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1111, 4'b0000, 4'b0000);
      checkCore("rr flush", 4'b0000, 1'b0, 1'b1, 1'b1);
      for (int s = 0; s < 2; s++) begin
        applyStimulus(4'b1111, 4'b0000, 4'b1111 & ~eg);
        checkCore("rr stream", eg, 1'b0, 1'b0, 1'b1);
      end
      applyStimulus(4'b1111, 4'b0000, eg);
      checkCore("rr last", eg, 1'b0, 1'b0, 1'b1);
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 4'b0000, 4'b0000);
      checkCore("rr release", 4'b0000, 1'b0, 1'b0, 1'b1);
    end

    // Requester 0 sends 1,1,0 with last on the third bit: one match.
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkCore("single idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkCore("single flush", 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    checkCore("single bit0", 4'b0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    checkCore("single bit1", 4'b0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 4'b0001);
    checkCore("single bit2", 4'b0001, 1'b0, 1'b0, 1'b1);
    checkMatch("single bit2", 1'b0, 2'd0, 8'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkCore("single release", 4'b0000, 1'b0, 1'b0, 1'b1);
    checkMatch("single release", 1'b1, 2'd0, 8'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkCore("single idle2", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkMatch("single idle2", 1'b0, 2'd0, 8'd1);

    // Requester 2 streams ones with no last: forced release after 16 bits,
    // S2 forced during IDLE/FLUSH must be ignored.
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b10);
    checkCore("long idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, 2'b10);
    checkCore("long flush", 4'b0000, 1'b0, 1'b1, 1'b1);
    checkMatch("long flush", 1'b0, 2'd0, 8'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b1, 2'b00);
      checkCore("long stream", 4'b0100, 1'b1, 1'b0, 1'b1);
      checkOutput("long stream/match_pulse", 8'(match_pulse), 8'd0);
    end
    applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b1, 2'b00);
    checkCore("long release", 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b1, 2'b00);
    checkCore("long gap idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b1, 2'b00);
    checkCore("long gap flush", 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b1, 2'b00);
      checkCore("long regrant", 4'b0100, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b1, 2'b00);
    checkCore("long abort", 4'b0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 2'b00);
    checkCore("long abort rel", 4'b0000, 1'b0, 1'b0, 1'b1);
    checkMatch("long abort rel", 1'b0, 2'd0, 8'd1);

    // Requester 1 wins after 2, sends one bit then aborts while
    // requester 0 is waiting; requester 0 wins next.
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    checkCore("abort idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    checkCore("abort flush", 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0011, 4'b0010, 4'b0000);
    checkCore("abort bit0", 4'b0010, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0010, 4'b0000);
    checkCore("abort cycle", 4'b0010, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkCore("abort release", 4'b0000, 1'b0, 1'b0, 1'b1);
    checkMatch("abort release", 1'b0, 2'd0, 8'd1);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkCore("abort idle2", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkMatch("abort idle2", 1'b0, 2'd0, 8'd1);

    // Requester 0 streaming, reset hits with S2 pending.
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    checkCore("rst flush", 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    checkCore("rst stream", 4'b0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1, 2'b10, 1'b1);
    checkOutput("rst cycle/fsm_rst", 8'(fsm_rst), 8'd1);
    checkOutput("rst cycle/grant", 8'(grant), 8'h01);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkCore("rst after", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkMatch("rst after", 1'b0, 2'd0, 8'd0);

    // 300 matching bursts from requester 2: counter saturates at 255.
    for (int n = 0; n < 254; n++) runBurst();
    checkMatch("sat 254", 1'b1, 2'd2, 8'd254);
    runBurst();
    checkMatch("sat 255", 1'b1, 2'd2, 8'd255);
    for (int n = 0; n < 45; n++) runBurst();
    checkMatch("sat 300", 1'b1, 2'd2, 8'd255);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkCore("sat idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    checkMatch("sat idle", 1'b0, 2'd2, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
